encoder_4x2: RTL

ENCODER_4X2 -- requirements
Module: encoder_4x2

---
 rtl/encoder_4x2.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/encoder_4x2.sv
// -----------------------------------------------------------------------------
// encoder_4x2
//   Priority encoder (i3 > i2 > i1 > i0) feeding a two-entry FIFO with a
//   valid/ready handshake on both sides. Each accepted word is encoded on the
//   accepting edge and the encoded entry waits in the FIFO until consumed.
//
//   Optional feature: define ENCODER_ONEHOT_CHECK_EN to flag words with two or
//   more request lines set (err=1 stored with the entry). Without the macro,
//   err is tied to 0 and the encoding is unchanged.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   i3..i0     in   request lines, i3 highest priority
//   in_valid   in   i3..i0 carry a word to encode
//   in_ready   out  a word can be accepted this cycle (combinational from state)
//   s1, s0     out  encoded index of head entry (s1 MSB), 0 when out_valid=0
//   zero       out  head entry had no line set, 0 when out_valid=0
//   err        out  head entry had more than one line set, 0 when out_valid=0
//   out_valid  out  head entry presented on s1/s0/zero/err
//   out_ready  in   consumer takes the head entry this cycle
//   count      out  number of buffered entries (0..2)
// -----------------------------------------------------------------------------
module encoder_4x2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i3,
    input  logic       i2,
    input  logic       i1,
    input  logic       i0,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       s1,
    output logic       s0,
    output logic       zero,
    output logic       err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Entry layout: {idx[1:0], zero, err}
    function automatic logic [3:0] encode_entry(input logic [3:0] w);
        logic [1:0] idx;
        logic       is_zero;
        logic       multi;
        casez (w)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            default: idx = 2'd0;
        endcase
        is_zero = (w == 4'b0000);
`ifdef ENCODER_ONEHOT_CHECK_EN
        // Clearing the lowest set bit leaves something only if >= 2 bits set.
        multi = ((w & (w - 4'd1)) != 4'b0000);
`else
        multi = 1'b0;
`endif
        return {idx, is_zero, multi};
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [3:0] head_r;
    logic [3:0] tail_r;
    logic [3:0] head_s;
    logic [3:0] tail_s;
    logic [3:0] new_entry_s;
    logic       push_s;
    logic       pop_s;
    logic [3:0] out_entry_r;
    logic       out_valid_r;
    logic [1:0] count_r;

    // Handshake qualifiers; in_ready is forced low while reset is asserted.
    always_comb begin
        in_ready    = rst_n && (state_r != ST_FULL);
        new_entry_s = encode_entry({i3, i2, i1, i0});
        push_s      = in_valid && in_ready;
        pop_s       = out_valid_r && out_ready;
    end

    // Next-state and FIFO slot update.
    always_comb begin
        state_s = state_r;
        head_s  = head_r;
        tail_s  = tail_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    head_s  = new_entry_s;
                    state_s = ST_ONE;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s && pop_s) begin
                    // Old head leaves, new word becomes head in the same edge.
                    head_s  = new_entry_s;
                    state_s = ST_ONE;
                end else if (push_s) begin
                    tail_s  = new_entry_s;
                    state_s = ST_FULL;
                end else if (pop_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    head_s  = tail_r;
                    state_s = ST_ONE;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // State, storage and registered output copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            head_r      <= 4'b0000;
            tail_r      <= 4'b0000;
            out_entry_r <= 4'b0000;
            out_valid_r <= 1'b0;
            count_r     <= 2'd0;
        end else begin
            state_r     <= state_s;
            head_r      <= head_s;
            tail_r      <= tail_s;
            out_valid_r <= (state_s != ST_EMPTY);
            out_entry_r <= (state_s != ST_EMPTY) ? head_s : 4'b0000;
            case (state_s)
                ST_EMPTY: count_r <= 2'd0;
                ST_ONE:   count_r <= 2'd1;
                ST_FULL:  count_r <= 2'd2;
                default:  count_r <= 2'd0;
            endcase
        end
    end

    // Output port mapping.
    always_comb begin
        s1        = out_entry_r[3];
        s0        = out_entry_r[2];
        zero      = out_entry_r[1];
        err       = out_entry_r[0];
        out_valid = out_valid_r;
        count     = count_r;
    end

endmodule
